// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates the instruction-fetch and
// store/load-buffer clients onto the 8-bit RAM/IO port, sequencing
// little-endian bytes and absorbing the one-cycle RAM read latency.
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        control_hazard,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        slb_req,
  input  logic        slb_wr,
  input  logic [1:0]  slb_size,
  input  logic [31:0] slb_addr,
  input  logic [31:0] slb_wdata,
  output logic        slb_done,
  output logic [31:0] slb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [2:0]  r_n;
  logic        r_owner_slb;
  logic        r_is_wr;
  logic        r_is_io;
  logic        r_if_done;
  logic        r_slb_done;
  logic [31:0] r_if_data;
  logic [31:0] r_slb_rdata;
  // The RAM keeps clocking while we are frozen, so the byte that belonged to
  // the previous address is saved on the first frozen edge and used instead
  // of mem_din on the first active edge afterwards.
  logic [7:0]  r_hold;
  logic        r_frozen;

  logic        w_accept_slb;
  logic        w_accept_if;
  logic        w_capture;
  logic        w_enter_done;
  logic        w_kill;
  logic        w_stall;
  logic [2:0]  w_slb_n;
  logic [7:0]  w_din;

  assign if_done   = r_if_done;
  assign slb_done  = r_slb_done;
  assign if_data   = r_if_data;
  assign slb_rdata = r_slb_rdata;

  assign w_din   = r_frozen ? r_hold : mem_din;
  assign w_stall = r_is_io && io_buffer_full;
  // Flush cancels anything without side effects: IF reads and non-IO loads.
  assign w_kill  = control_hazard && (r_state != IDLE) &&
                   (!r_owner_slb || (!r_is_wr && !r_is_io));

  // Decode SLB access size into a byte count (size 3 behaves as a word).
  always_comb begin
    w_slb_n = 3'd4;
    case (slb_size)
      2'd0:    w_slb_n = 3'd1;
      2'd1:    w_slb_n = 3'd2;
      default: w_slb_n = 3'd4;
    endcase
  end

  // State register and byte counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else if (rdy_in) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic plus the RAM port drive for the current byte.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept_slb = 1'b0;
    w_accept_if  = 1'b0;
    w_capture    = 1'b0;
    w_enter_done = 1'b0;
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = 3'd0;
        if (!control_hazard) begin
          if (slb_req) begin
            w_accept_slb = 1'b1;
            w_state_next = slb_wr ? WRITE : READ;
          end else if (if_req) begin
            w_accept_if  = 1'b1;
            w_state_next = READ;
          end
        end
      end
      READ: begin
        // Address phase for bytes 0..N-1, then one extra cycle to capture
        // the last byte while the address bus returns to zero.
        if (r_cnt < r_n) begin
          mem_a = r_base + {29'd0, r_cnt};
        end
        w_capture = (r_cnt != 3'd0);
        if (r_cnt == r_n) begin
          w_state_next = DONE;
          w_enter_done = 1'b1;
          w_cnt_next   = 3'd0;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      WRITE: begin
        mem_a = r_base + {29'd0, r_cnt};
        case (r_cnt[1:0])
          2'd0:    mem_dout = r_wdata[7:0];
          2'd1:    mem_dout = r_wdata[15:8];
          2'd2:    mem_dout = r_wdata[23:16];
          default: mem_dout = r_wdata[31:24];
        endcase
        if (!w_stall) begin
          mem_wr = 1'b1;
          if (r_cnt == r_n - 3'd1) begin
            w_state_next = DONE;
            w_enter_done = 1'b1;
            w_cnt_next   = 3'd0;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 3'd0;
      end
    endcase
    if (w_kill) begin
      w_state_next = IDLE;
      w_cnt_next   = 3'd0;
      w_enter_done = 1'b0;
      w_capture    = 1'b0;
    end
    if (!rdy_in) begin
      mem_wr = 1'b0;
    end
  end

  // Request latching, byte assembly and done pulses.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_n         <= 3'd0;
      r_owner_slb <= 1'b0;
      r_is_wr     <= 1'b0;
      r_is_io     <= 1'b0;
      r_if_done   <= 1'b0;
      r_slb_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_slb_rdata <= 32'd0;
      r_hold      <= 8'd0;
      r_frozen    <= 1'b0;
    end else if (rdy_in) begin
      r_frozen <= 1'b0;
      if (w_accept_slb) begin
        r_base      <= slb_addr;
        r_n         <= w_slb_n;
        r_wdata     <= slb_wdata;
        r_owner_slb <= 1'b1;
        r_is_wr     <= slb_wr;
        r_is_io     <= (slb_addr[17:16] == IO_SEL);
        if (!slb_wr) begin
          r_slb_rdata <= 32'd0;
        end
      end else if (w_accept_if) begin
        r_base      <= if_addr;
        r_n         <= 3'd4;
        r_wdata     <= 32'd0;
        r_owner_slb <= 1'b0;
        r_is_wr     <= 1'b0;
        r_is_io     <= (if_addr[17:16] == IO_SEL);
        r_if_data   <= 32'd0;
      end
      if (w_capture) begin
        if (r_owner_slb) begin
          case (r_cnt)
            3'd1:    r_slb_rdata[7:0]   <= w_din;
            3'd2:    r_slb_rdata[15:8]  <= w_din;
            3'd3:    r_slb_rdata[23:16] <= w_din;
            default: r_slb_rdata[31:24] <= w_din;
          endcase
        end else begin
          case (r_cnt)
            3'd1:    r_if_data[7:0]   <= w_din;
            3'd2:    r_if_data[15:8]  <= w_din;
            3'd3:    r_if_data[23:16] <= w_din;
            default: r_if_data[31:24] <= w_din;
          endcase
        end
      end
      if (w_enter_done) begin
        if (r_owner_slb) begin
          r_slb_done <= 1'b1;
        end else begin
          r_if_done <= 1'b1;
        end
      end else if (r_state == DONE) begin
        r_if_done  <= 1'b0;
        r_slb_done <= 1'b0;
      end
    end else begin
      if (!r_frozen) begin
        r_hold <= mem_din;
      end
      r_frozen <= 1'b1;
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the core's two memory clients and the 8-bit RAM/IO port.
- Clients are instruction fetch (IF, 32-bit reads) and the store/load buffer (SLB, 1/2/4-byte reads and writes).
- Arbitrates between the clients, sequences little-endian bytes and absorbs the 1-cycle RAM read latency.
- Throttles IO writes on io_buffer_full and aborts speculative reads on control_hazard.

Parameters:
- IO_SEL, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous reset, active-low
- rdy_in  input  1  global enable; low freezes the block
- control_hazard  input  1  pipeline flush
- if_req  input  1  IF read request, held until if_done
- if_addr  input  32  IF word address
- if_done  output  1  one-cycle pulse; if_data valid
- if_data  output  32  fetched word
- slb_req  input  1  SLB request, held until slb_done
- slb_wr  input  1  1 = store, 0 = load
- slb_size  input  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- slb_addr  input  32  SLB base address
- slb_wdata  input  32  store data, byte 0 written first
- slb_done  output  1  one-cycle pulse; access complete
- slb_rdata  output  32  load data, zero-extended
- mem_din  input  8  RAM/IO read byte, valid the cycle after its address
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  write strobe
- io_buffer_full  input  1  UART tx buffer full

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset (rst_in=0 at posedge): state=IDLE, if_done=slb_done=0, mem_wr=0, mem_a=0, mem_dout=0, if_data=slb_rdata=0, byte counters=0.
- rdy_in=0: no state, counter or data register changes; mem_wr forced 0; mem_a holds its value. Done pulses stretch until rdy_in returns.
- Arbitration in IDLE:
  - slb_req has priority over if_req.
  - At the accepting edge, latch base address, N (IF: 4; SLB: 1/2/4), write data, owner, and isIO = (base[17:16]==IO_SEL).
  - Next state is READ or WRITE.
- Address arithmetic: mem_a = base + i, 32-bit modular. The base is never realigned.
- READ:
  - Cycles 1..N after accept drive mem_a = base+0 .. base+N-1.
  - Byte i is captured from mem_din one cycle after its address and placed at bits [8i+7:8i]; upper bytes are 0.
  - In cycle N+1, mem_a = 0 while the last byte is captured.
  - State goes to DONE at the end of cycle N+1.
- WRITE:
  - Each cycle drives mem_a = base+i, mem_dout = byte i, mem_wr = 1, then i advances.
  - If isIO && io_buffer_full in a cycle: mem_wr = 0 and i holds (stall).
  - State goes to DONE after byte N-1 has been written.
- DONE:
  - Lasts exactly one cycle. The owner's done is 1 and its data register is stable.
  - Requests are ignored during DONE, so a still-held req is not re-accepted.
  - State returns to IDLE.
- Latency:
  - Read: done is high in cycle N+2 after the accepting edge. A word fetch therefore sees done 6 cycles after accept.
  - Write without stall: done is high in cycle N+1 after accept.
- Flush (control_hazard=1 at a posedge):
  - Any state with an IF owner → IDLE; if_done is not pulsed.
  - A non-IO SLB load → IDLE; slb_done is not pulsed.
  - SLB writes and IO loads always run to completion, including their done pulse (side effects).
  - Flush in IDLE has no effect, and a request present that cycle is not accepted.
- mem_wr is only ever 1 in WRITE. mem_a = 0 in IDLE and DONE.
- Done outputs are registered and are never high together.

Test Plan:
- Word fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 → mem_a 0x100..0x103 on consecutive cycles; if_done in cycle 6 after accept; if_data=0x00000513.
- Simultaneous requests: if_req and slb_req (load, byte, 0x200, RAM=0xAB) both high → SLB served first; slb_rdata=0x000000AB. IF is then accepted the cycle after DONE.
- Half store: slb_wr=1, size=1, addr=0x1FFFF, wdata=0x1234 → mem_wr at 0x1FFFF with 0x34, then 0x20000 with 0x12; slb_done the next cycle.
- IO stall: byte store 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those cycles; the single write occurs when full drops; slb_done one cycle later.
- Flush: control_hazard pulsed in cycle 3 of a word fetch → no if_done and state returns to IDLE. The same pulse during an IO load from 0x30000 → load completes and slb_done is pulsed.
- Freeze and reset: rdy_in=0 for 2 cycles mid-read → mem_wr=0, data and timing shift by 2 cycles, result unchanged. rst_in=0 mid-write → next cycle is IDLE with all outputs 0.
